// File: rtl/reg_scoreboard.sv
// Register scoreboard for the ID stage: one countdown per architectural register
// tracks in-flight writes and decides whether the instruction in ID may issue.
module reg_scoreboard #(
    parameter int NREG    = 32,
    parameter int NSRC    = 2,
    parameter int MAX_LAT = 4,
    localparam int AW     = $clog2(NREG),
    localparam int LW     = $clog2(MAX_LAT + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 issue_valid_i,
    input  logic                 issue_we_i,
    input  logic [AW-1:0]        issue_rd_i,
    input  logic [LW-1:0]        issue_lat_i,
    input  logic                 flush_i,
    input  logic [NSRC-1:0]      src_used_i,
    input  logic [NSRC*AW-1:0]   src_addr_i,
    output logic [NSRC-1:0]      src_busy_o,
    output logic                 waw_o,
    output logic                 stall_o,
    output logic                 issue_accept_o,
    output logic [NREG-1:0]      pending_o
);

    localparam logic [LW-1:0] MAX_LAT_L = LW'(MAX_LAT);

    // Handshake: issue_valid_i holds an instruction in ID; it leaves ID only in a
    // cycle where issue_accept_o is high, and stall_o asks PC/IF_ID to hold it.
    logic [LW-1:0] cnt      [NREG];
    logic [LW-1:0] cnt_next [NREG];
    logic [LW-1:0] eff_lat;
    logic [LW-1:0] rd_cnt;
    logic          load_en;

    always_comb begin
        eff_lat = (issue_lat_i > MAX_LAT_L) ? MAX_LAT_L : issue_lat_i;
    end

    // Register 0 never matches here, so rd_cnt is zero for it.
    always_comb begin
        rd_cnt = '0;
        for (int r = 1; r < NREG; r++) begin
            if (issue_rd_i == AW'(r)) begin
                rd_cnt = cnt[r];
            end
        end
    end

    always_comb begin
        src_busy_o = '0;
        for (int k = 0; k < NSRC; k++) begin
            for (int r = 1; r < NREG; r++) begin
                if (src_used_i[k] && (src_addr_i[k*AW +: AW] == AW'(r)) && (cnt[r] != '0)) begin
                    src_busy_o[k] = 1'b1;
                end
            end
        end
    end

    // A slower in-flight write to the same register would land after this one.
    always_comb begin
        waw_o          = issue_valid_i & issue_we_i & (issue_rd_i != '0) & (rd_cnt > eff_lat);
        stall_o        = issue_valid_i & ((|src_busy_o) | waw_o);
        issue_accept_o = issue_valid_i & ~stall_o & ~flush_i;
        load_en        = issue_accept_o & issue_we_i & (issue_rd_i != '0);
    end

    // A fresh load takes priority over the decrement of the same register.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            cnt_next[r] = cnt[r];
            if (r == 0) begin
                cnt_next[r] = '0;
            end else if (load_en && (issue_rd_i == AW'(r))) begin
                cnt_next[r] = eff_lat;
            end else if (cnt[r] != '0) begin
                cnt_next[r] = cnt[r] - LW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= cnt_next[r];
            end
        end
    end

    always_comb begin
        pending_o = '0;
        for (int r = 1; r < NREG; r++) begin
            pending_o[r] = (cnt[r] != '0);
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: directed scenarios plus random traffic, checked
// against a model that tracks the absolute cycle at which each register frees.
module tb_reg_scoreboard;

    localparam int NREG    = 32;
    localparam int NSRC    = 3;
    localparam int MAX_LAT = 4;
    localparam int AW      = 5;
    localparam int LW      = 3;

    logic                clk = 1'b0;
    logic                rst_i;
    logic                issue_valid;
    logic                issue_we;
    logic [AW-1:0]       issue_rd;
    logic [LW-1:0]       issue_lat;
    logic                flush;
    logic [NSRC-1:0]     src_used;
    logic [NSRC*AW-1:0]  src_addr;
    logic [NSRC-1:0]     src_busy_o;
    logic                waw_o;
    logic                stall_o;
    logic                issue_accept_o;
    logic [NREG-1:0]     pending_o;

    always #5 clk = ~clk;

    reg_scoreboard #(.NREG(NREG), .NSRC(NSRC), .MAX_LAT(MAX_LAT)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .issue_valid_i  (issue_valid),
        .issue_we_i     (issue_we),
        .issue_rd_i     (issue_rd),
        .issue_lat_i    (issue_lat),
        .flush_i        (flush),
        .src_used_i     (src_used),
        .src_addr_i     (src_addr),
        .src_busy_o     (src_busy_o),
        .waw_o          (waw_o),
        .stall_o        (stall_o),
        .issue_accept_o (issue_accept_o),
        .pending_o      (pending_o)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Model: free_at[r] is the cycle index from which register r is no longer busy.
    int free_at [NREG];
    int cyc = 0;
    logic [NSRC-1:0] e_busy;
    logic            e_waw, e_stall, e_accept;
    logic [NREG-1:0] e_pend;
    int              e_eff;

    function automatic int rem(input int r);
        if (r == 0) return 0;
        return (free_at[r] > cyc) ? free_at[r] - cyc : 0;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < NREG; r++) free_at[r] = 0;
    endtask

    task automatic model_eval();
        int a;
        e_eff = (int'(issue_lat) > MAX_LAT) ? MAX_LAT : int'(issue_lat);
        for (int k = 0; k < NSRC; k++) begin
            a = int'(src_addr[k*AW +: AW]);
            e_busy[k] = src_used[k] && (a != 0) && (rem(a) > 0);
        end
        e_waw    = issue_valid && issue_we && (issue_rd != 0) && (rem(int'(issue_rd)) > e_eff);
        e_stall  = issue_valid && ((|e_busy) || e_waw);
        e_accept = issue_valid && !e_stall && !flush;
        for (int r = 0; r < NREG; r++) e_pend[r] = (rem(r) > 0);
    endtask

    task automatic check_all(input string tag);
        model_eval();
        chk({tag, ".busy"},   src_busy_o,     e_busy);
        chk({tag, ".waw"},    waw_o,          e_waw);
        chk({tag, ".stall"},  stall_o,        e_stall);
        chk({tag, ".accept"}, issue_accept_o, e_accept);
        chk({tag, ".pend"},   pending_o,      e_pend);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_i) begin
            model_clear();
        end else if (e_accept && issue_we && issue_rd != 0) begin
            free_at[issue_rd] = cyc + 1 + e_eff;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic we, input int rd, input int lat,
                         input logic fl, input logic [NSRC-1:0] used,
                         input int a0, input int a1, input int a2);
        issue_valid = v;
        issue_we    = we;
        issue_rd    = AW'(rd);
        issue_lat   = LW'(lat);
        flush       = fl;
        src_used    = used;
        src_addr    = {AW'(a2), AW'(a1), AW'(a0)};
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 0, 0, 0, 0, '0, 0, 0, 0);
            check_all("idle");
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        int n_waw;
        logic acc;
        model_clear();
        rst_i = 1'b0;
        drive(0, 0, 0, 0, 0, '0, 0, 0, 0);
        @(negedge clk);

        // Issue during reset must not mark anything.
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, 5, 3, 0, '0, 0, 0, 0);
            check_all("rst");
            chk("rst.pend0", pending_o, '0);
            tick();
        end
        rst_i = 1'b1;
        drive(1, 0, 0, 0, 0, 3'b001, 5, 0, 0);
        check_all("rst_rel");
        chk("rst_rel.stall", stall_o, 1'b0);
        chk("rst_rel.pend", pending_o, '0);
        tick();

        // Load-use with latency 2.
        drive(1, 1, 8, 2, 0, '0, 0, 0, 0);
        check_all("lu_issue");
        chk("lu_issue.acc", issue_accept_o, 1'b1);
        tick();
        drive(1, 0, 0, 0, 0, 3'b001, 8, 0, 0);
        check_all("lu_c1");
        chk("lu_c1.stall", stall_o, 1'b1);
        tick();
        check_all("lu_c2");
        chk("lu_c2.stall", stall_o, 1'b1);
        tick();
        check_all("lu_c3");
        chk("lu_c3.acc", issue_accept_o, 1'b1);
        chk("lu_c3.pend8", pending_o[8], 1'b0);
        tick();

        // Register 0 is never tracked.
        drive(1, 1, 0, 4, 0, '0, 0, 0, 0);
        check_all("r0_issue");
        tick();
        drive(1, 0, 0, 0, 0, 3'b001, 0, 0, 0);
        check_all("r0_use");
        chk("r0_use.pend", pending_o, '0);
        chk("r0_use.stall", stall_o, 1'b0);
        tick();

        // Write-after-write: younger faster write waits until it would land last.
        drive(1, 1, 3, 4, 0, '0, 0, 0, 0);
        check_all("waw_first");
        tick();
        drive(1, 1, 3, 1, 0, '0, 0, 0, 0);
        n_waw = 0;
        acc   = 1'b0;
        for (int i = 0; i < 8 && !acc; i++) begin
            check_all("waw_loop");
            if (waw_o) n_waw++;
            if (issue_accept_o) acc = 1'b1;
            tick();
        end
        chk("waw.acc", acc, 1'b1);
        chk("waw.cycles", n_waw, 3);
        drive(0, 0, 0, 0, 0, '0, 0, 0, 0);
        check_all("waw_after");
        chk("waw_after.pend3", pending_o[3], 1'b1);
        tick();
        idle(5);

        // Flush: squashed issue leaves tracking alone, older count still decrements.
        drive(1, 1, 9, 2, 0, '0, 0, 0, 0);
        check_all("fl_set");
        tick();
        drive(1, 1, 10, 3, 1, '0, 0, 0, 0);
        check_all("fl_flush");
        chk("fl_flush.acc", issue_accept_o, 1'b0);
        tick();
        drive(0, 0, 0, 0, 0, '0, 0, 0, 0);
        check_all("fl_after");
        chk("fl_after.pend10", pending_o[10], 1'b0);
        chk("fl_after.pend9", pending_o[9], 1'b1);
        tick();
        check_all("fl_done");
        chk("fl_done.pend9", pending_o[9], 1'b0);
        tick();

        // Clamped latency on channel 2 only.
        drive(1, 1, 7, 7, 0, '0, 0, 0, 0);
        check_all("cl_issue");
        tick();
        drive(1, 0, 0, 0, 0, 3'b100, 7, 7, 7);
        for (int i = 0; i < 4; i++) begin
            check_all("cl_wait");
            chk("cl_wait.busy", src_busy_o, 3'b100);
            tick();
        end
        check_all("cl_free");
        chk("cl_free.busy", src_busy_o, 3'b000);
        tick();

        // Async reset pulse mid-countdown.
        drive(1, 1, 7, 7, 0, '0, 0, 0, 0);
        check_all("ar_issue");
        tick();
        drive(1, 0, 0, 0, 0, 3'b100, 0, 0, 7);
        check_all("ar_busy");
        chk("ar_busy.busy", src_busy_o, 3'b100);
        #1 rst_i = 1'b0;
        model_clear();
        #1;
        check_all("ar_mid");
        chk("ar_mid.busy", src_busy_o, 3'b000);
        tick();
        rst_i = 1'b1;
        #1;
        check_all("ar_rel");
        chk("ar_rel.stall", stall_o, 1'b0);
        tick();

        // Random traffic over a small register window to force hazards.
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 7) == 0, NSRC'($urandom_range(0, 7)),
                  $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
            check_all("rnd");
            if ($urandom_range(0, 149) == 0) begin
                #1 rst_i = 1'b0;
                model_clear();
                #1;
                check_all("rnd_arst");
                tick();
                rst_i = 1'b1;
                #1;
                check_all("rnd_rel");
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
